// File: rtl/memory_responder.sv
// memory_responder: single-port word memory answering one request at a time with fixed latency.
//   clk        : clock, all state updates on the rising edge
//   reset      : asynchronous active-high reset
//   mem_in     : request bundle (req_valid, req.addr, req.data, req.fcn, req.typ)
//   mem_out    : response bundle (res_valid, res.data)
//   misaligned : high with res_valid when the completing request was misaligned
package memory_bundle_pkg;
    localparam logic [1:0] M_XRD = 2'd0;
    localparam logic [1:0] M_XWR = 2'd1;
    localparam logic [2:0] MT_B  = 3'd1;
    localparam logic [2:0] MT_H  = 3'd2;
    localparam logic [2:0] MT_W  = 3'd3;
    localparam logic [2:0] MT_BU = 3'd4;
    localparam logic [2:0] MT_HU = 3'd5;
    localparam logic [2:0] MT_WU = 3'd6;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  fcn;
        logic [2:0]  typ;
    } mem_req_t;
    typedef struct packed {
        logic     req_valid;
        mem_req_t req;
    } memory_in_t;
    typedef struct packed {
        logic [31:0] data;
    } mem_resp_t;
    typedef struct packed {
        logic      res_valid;
        mem_resp_t res;
    } memory_out_t;
endpackage

module memory_responder
    import memory_bundle_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  memory_in_t  mem_in,
    output memory_out_t mem_out,
    output logic        misaligned
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem [DEPTH_WORDS];
    logic          legal, wr, half, word, mis_c, we, valid;
    logic [2:0]    typ_e;
    logic [AW-1:0] idx, w_idx;
    logic [3:0]    mask, w_mask;
    logic [31:0]   wdata, w_data, rd_c, res_data;
    logic          unused_in;

    // Only part of the address and data is consumed; fold the whole bundle here.
    assign unused_in = ^mem_in;

    function automatic logic [31:0] fmt(input logic [31:0] w, input logic [1:0] a, input logic [2:0] t);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        return t == MT_B  ? {{24{b[7]}}, b} :
               t == MT_BU ? {24'b0, b} :
               t == MT_H  ? {{16{h[15]}}, h} :
               t == MT_HU ? {16'b0, h} : w;
    endfunction

    // Unknown fcn/typ encodings degrade to a plain word read.
    always_comb begin
        legal = (mem_in.req.fcn == M_XRD || mem_in.req.fcn == M_XWR) &&
                (mem_in.req.typ inside {MT_B, MT_H, MT_W, MT_BU, MT_HU, MT_WU});
        typ_e = legal ? mem_in.req.typ : MT_W;
        wr    = legal && mem_in.req.fcn == M_XWR;
        half  = typ_e inside {MT_H, MT_HU};
        word  = typ_e inside {MT_W, MT_WU};
        mis_c = half ? mem_in.req.addr[0] : (word && mem_in.req.addr[1:0] != 2'b00);
        idx   = mem_in.req.addr[2 +: AW];
        mask  = word ? 4'hf : half ? (mem_in.req.addr[1] ? 4'hc : 4'h3) : 4'b0001 << mem_in.req.addr[1:0];
        wdata = word ? mem_in.req.data : half ? {2{mem_in.req.data[15:0]}} : {4{mem_in.req.data[7:0]}};
        rd_c  = (wr || mis_c) ? 32'h0 : fmt(mem[idx], mem_in.req.addr[1:0], typ_e);
    end

    always_ff @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (we && w_mask[i]) mem[w_idx][8*i +: 8] <= w_data[8*i +: 8];

    if (LATENCY == 0) begin : g_comb
        assign valid      = mem_in.req_valid && !reset;
        assign we         = valid && wr && !mis_c;
        assign w_idx      = idx;
        assign w_mask     = mask;
        assign w_data     = wdata;
        assign res_data   = valid ? rd_c : 32'h0;
        assign misaligned = valid && mis_c;
    end else begin : g_fsm
        typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
        localparam logic [3:0] CNT_INIT = LATENCY >= 2 ? 4'(LATENCY - 2) : 4'd0;
        state_t        state, state_d;
        logic [3:0]    count, count_d;
        logic          accept, mis_q, wr_q;
        logic [31:0]   rsp_q, wdata_q;
        logic [AW-1:0] idx_q;
        logic [3:0]    mask_q;

        always_comb begin
            state_d = state;
            count_d = count;
            accept  = 1'b0;
            case (state)
                IDLE: if (mem_in.req_valid) begin
                    accept  = 1'b1;
                    state_d = LATENCY == 1 ? RESP : WAIT;
                    count_d = CNT_INIT;
                end
                WAIT: if (count == 4'd0) state_d = RESP;
                      else count_d = count - 4'd1;
                RESP: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // The store is captured at accept so it commits correctly even if the
        // requester moves on as soon as it sees res_valid.
        always_ff @(posedge clk or posedge reset)
            if (reset) begin
                state   <= IDLE;
                count   <= 4'd0;
                rsp_q   <= 32'h0;
                mis_q   <= 1'b0;
                wr_q    <= 1'b0;
                idx_q   <= '0;
                mask_q  <= 4'h0;
                wdata_q <= 32'h0;
            end else begin
                state <= state_d;
                count <= count_d;
                if (accept) begin
                    rsp_q   <= rd_c;
                    mis_q   <= mis_c;
                    wr_q    <= wr && !mis_c;
                    idx_q   <= idx;
                    mask_q  <= mask;
                    wdata_q <= wdata;
                end
            end

        assign valid      = state == RESP;
        assign we         = valid && wr_q;
        assign w_idx      = idx_q;
        assign w_mask     = mask_q;
        assign w_data     = wdata_q;
        assign res_data   = valid ? rsp_q : 32'h0;
        assign misaligned = valid && mis_q;
    end

    assign mem_out = {valid, res_data};
endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words; SHALL be a power of two in the range 4..65536.
REQ-002 Parameter LATENCY, default 1: number of cycles from request acceptance to response; legal range 0..15.
REQ-003 Port clk  input  1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1: asynchronous, active-high reset.
REQ-005 Port mem_in  input  Bundle::MemoryIn: req_valid, req.addr[31:0], req.data[31:0], req.fcn (M_XRD/M_XWR), req.typ (MT_B/H/W/BU/HU/WU).
REQ-006 Port mem_out  output  Bundle::MemoryOut: res_valid, res.data[31:0].
REQ-007 Port misaligned  output  1: asserted together with res_valid when the completing request was misaligned.

Function
REQ-008 Word index SHALL be addr[2 +: log2(DEPTH_WORDS)]; higher address bits SHALL be ignored, so accesses wrap modulo the array size.
REQ-009 Misaligned: H/HU with addr[0]=1, or W/WU with addr[1:0]!=0; B/BU are never misaligned.
REQ-010 Only one request SHALL be outstanding; the requester holds mem_in stable until it sees res_valid=1.
REQ-011 For LATENCY>=1, the FSM SHALL have the states IDLE, WAIT and RESP.
REQ-012 IDLE: a request with req_valid=1 SHALL be accepted at the rising edge; the FSM SHALL go to RESP if LATENCY=1, otherwise to WAIT with count=LATENCY-2.
REQ-013 WAIT: the FSM SHALL go to RESP when count=0, otherwise decrement count.
REQ-014 RESP: res_valid=1 for exactly one cycle, then the FSM SHALL return to IDLE unconditionally; a request present during RESP SHALL NOT be accepted.
REQ-015 Consequence of REQ-012..014: for LATENCY=L>=1, res_valid is high in the L-th cycle after the accept edge; throughput is one request per L+1 cycles.
REQ-016 Read data SHALL be sampled from the array at the accept edge into a response register.
REQ-017 res.data SHALL equal the response register during RESP and 0 otherwise.
REQ-018 Load formatting by typ: B selects byte lane addr[1:0] and sign-extends; BU zero-extends it; H selects halfword lane addr[1] and sign-extends; HU zero-extends it; W/WU pass the full word.
REQ-019 Stores (fcn=M_XWR) SHALL commit at the edge that leaves RESP: B writes one byte lane, H writes two lanes, W writes four lanes, from the corresponding low bits of req.data; other lanes are unchanged.
REQ-020 A misaligned request SHALL still complete with normal timing, with misaligned=1, res.data=0, and no write.
REQ-021 For stores, res.data SHALL be 0.
REQ-022 LATENCY=0: no FSM; res_valid SHALL equal req_valid combinationally.
REQ-023 LATENCY=0: res.data SHALL be the formatted combinational read of the current address.
REQ-024 LATENCY=0: stores SHALL commit at every rising edge where req_valid=1 and the access is aligned.
REQ-025 LATENCY=0: a read of an address in the same cycle as its write SHALL return the old data.
REQ-026 fcn or typ values outside the listed encodings SHALL be treated as a W read.

Reset
REQ-027 Reset SHALL asynchronously force FSM=IDLE, count=0, response register=0, res_valid=0, misaligned=0 and res.data=0.
REQ-028 A request in WAIT or RESP when reset asserts SHALL be dropped; its pending store SHALL NOT commit.
REQ-029 Array contents SHALL NOT be reset.
REQ-030 The first request after reset deassertion SHALL be accepted at the first rising edge with reset=0.

Verification
REQ-031 LATENCY=1: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> res_valid high 1 cycle after each accept; load returns 0xDEADBEEF; 4 cycles per pair.
REQ-032 Word 0x20=0x80FF7F01: LB 0x21 -> 0x0000007F; LB 0x23 -> 0xFFFFFF80; LBU 0x22 -> 0x000000FF; LH 0x22 -> 0xFFFF80FF; LHU 0x20 -> 0x00007F01.
REQ-033 SB 0x31 data 0xAA over word 0x11223344, then LW 0x30 -> 0x1122AA44; SH 0x32 data 0x5566 -> 0x5566AA44.
REQ-034 LW 0x41 -> misaligned=1 and res.data=0; SH 0x43 -> no change to word 0x40.
REQ-035 LATENCY=4: SW accepted, reset pulsed in WAIT -> res_valid stays 0, word unchanged, the next request completes 4 cycles after its accept.
REQ-036 DEPTH_WORDS=1024: SW 0x1000 data 0x1 -> LW 0x0000 returns 0x1 (wrap).
